// File: rtl/ui_uart_pkg.sv
// ui_uart_pkg: shared FSM/parity types and legal parameter ranges for the UART receiver
package ui_uart_pkg;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } rx_state_e;
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_e;
  function automatic logic parity_on(input parity_e m);
    return m == PAR_EVEN || m == PAR_ODD;
  endfunction
endpackage

// File: rtl/ui_uart_rx_out_reg.sv
// ui_uart_rx_out_reg: holds the received character and flags behind a valid/ready handshake
module ui_uart_rx_out_reg #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 par_err,
  input  logic                 frm_err,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_par_err,
  output logic                 rx_frm_err,
  output logic                 ovr_err
);
  // a full register only takes a new character when it is being drained this same clk
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_par_err <= 1'b0;
      rx_frm_err <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      ovr_err <= load && rx_valid && !rx_ready;
      if (load && (!rx_valid || rx_ready)) begin
        rx_data    <= data;
        rx_par_err <= par_err;
        rx_frm_err <= frm_err;
        rx_valid   <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ui_uart_rx_cfg.sv
// ui_uart_rx_cfg: oversampling UART receiver with runtime parity/stop config, break and overrun detection
module ui_uart_rx_cfg
  import ui_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rxd_clk_sys,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_par_err,
  output logic                 rx_frm_err,
  output logic                 ovr_err,
  output logic                 brk_det
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  parity_e              pmode;
  logic                 two_stop;
  logic                 par_bit;
  logic                 stop1_low;
  logic                 last_stop;
  logic                 is_brk;
  logic                 frm_now;
  logic                 par_now;
  logic                 load;
  // last stop sample closes the character; break needs every sampled bit low
  always_comb begin
    last_stop = (state == STOP1 && !two_stop) || state == STOP2;
    is_brk    = shreg == '0 && (!parity_on(pmode) || !par_bit) && !rxd_clk_sys &&
                (state == STOP1 || stop1_low);
    frm_now   = !rxd_clk_sys || (state == STOP2 && stop1_low);
    par_now   = pmode == PAR_EVEN ? ^shreg ^ par_bit :
                pmode == PAR_ODD  ? ~(^shreg ^ par_bit) : 1'b0;
    load      = baud_en && cnt == '0 && last_stop && !is_brk;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      pmode     <= PAR_NONE;
      two_stop  <= 1'b0;
      par_bit   <= 1'b0;
      stop1_low <= 1'b0;
      brk_det   <= 1'b0;
    end else begin
      brk_det <= 1'b0;
      if (baud_en) begin
        case (state)
          IDLE: if (!rxd_clk_sys) begin
            state <= START;
            cnt   <= HALF;
          end
          START: if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rxd_clk_sys) begin
            state    <= DATA;
            cnt      <= FULL;
            bit_cnt  <= '0;
            pmode    <= parity_e'(parity_mode);
            two_stop <= stop2;
          end else state <= IDLE;
          DATA: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg   <= {rxd_clk_sys, shreg[DATA_BITS-1:1]};
            cnt     <= FULL;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST) state <= parity_on(pmode) ? PARITY : STOP1;
          end
          PARITY: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            par_bit <= rxd_clk_sys;
            cnt     <= FULL;
            state   <= STOP1;
          end
          STOP1: if (cnt != '0) cnt <= cnt - 1'b1;
          else if (two_stop) begin
            stop1_low <= !rxd_clk_sys;
            cnt       <= FULL;
            state     <= STOP2;
          end else begin
            state   <= is_brk ? BRK_WAIT : IDLE;
            brk_det <= is_brk;
          end
          STOP2: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state   <= is_brk ? BRK_WAIT : IDLE;
            brk_det <= is_brk;
          end
          BRK_WAIT: if (rxd_clk_sys) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
  ui_uart_rx_out_reg #(.DATA_BITS(DATA_BITS)) u_out (
    .clk(clk),
    .rst(rst),
    .load(load),
    .data(shreg),
    .par_err(par_now),
    .frm_err(frm_now),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_par_err(rx_par_err),
    .rx_frm_err(rx_frm_err),
    .ovr_err(ovr_err)
  );
endmodule

// File: tb/tb_ui_uart_rx_cfg.sv
// tb_ui_uart_rx_cfg: random and directed frames against a frame-level reference model, two configurations
module tb_ui_uart_rx_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, baud_en = 1'b0;
  logic rxd_a = 1'b1, ready_a = 1'b1, stop2_a = 1'b0;
  logic [1:0] pm_a = 2'b00;
  logic [7:0] data_a;
  logic valid_a, par_a, frm_a, ovr_a, brk_a;
  logic rxd_b = 1'b1, ready_b = 1'b1, stop2_b = 1'b0;
  logic [1:0] pm_b = 2'b00;
  logic [4:0] data_b;
  logic valid_b, par_b, frm_b, ovr_b, brk_b;
  ui_uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst(rst), .baud_en(baud_en), .rxd_clk_sys(rxd_a),
    .parity_mode(pm_a), .stop2(stop2_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .rx_par_err(par_a), .rx_frm_err(frm_a),
    .ovr_err(ovr_a), .brk_det(brk_a));
  ui_uart_rx_cfg #(.DATA_BITS(5), .OVERSAMPLE(8)) dut_b (
    .clk(clk), .rst(rst), .baud_en(baud_en), .rxd_clk_sys(rxd_b),
    .parity_mode(pm_b), .stop2(stop2_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .rx_par_err(par_b), .rx_frm_err(frm_b),
    .ovr_err(ovr_b), .brk_det(brk_b));
  int total = 0, bad = 0;
  logic [10:0] got_a[$], got_b[$];
  int nbrk_a = 0, novr_a = 0, nbrk_b = 0, novr_b = 0;
  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back({par_a, frm_a, 1'b0, data_a});
    if (valid_b && ready_b) got_b.push_back({par_b, frm_b, 4'b0, data_b});
    if (brk_a) nbrk_a++;
    if (ovr_a) novr_a++;
    if (brk_b) nbrk_b++;
    if (ovr_b) novr_b++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    baud_en = 1'b1;
    @(negedge clk);
    baud_en = 1'b0;
  endtask
  task automatic clr();
    got_a.delete();
    got_b.delete();
    nbrk_a = 0; novr_a = 0; nbrk_b = 0; novr_b = 0;
  endtask
  task automatic idle(input int sel, input int nbits);
    if (sel == 0) rxd_a = 1'b1; else rxd_b = 1'b1;
    repeat (nbits * (sel == 0 ? 16 : 8)) tick();
  endtask
  task automatic build(input int nb, input logic [8:0] d, input logic [1:0] pm, input logic pb,
                       input logic s1, input logic s2, input logic st2,
                       output logic [15:0] v, output int n);
    v = '0;
    v[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      v[n] = d[i];
      n++;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      v[n] = pb;
      n++;
    end
    v[n] = s1;
    n++;
    if (st2) begin
      v[n] = s2;
      n++;
    end
  endtask
  task automatic send(input int sel, input logic [15:0] v, input int n, input logic scramble);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd_a = v[i]; else rxd_b = v[i];
      if (scramble && i == 3) begin
        if (sel == 0) begin
          pm_a = 2'($urandom);
          stop2_a = 1'($urandom);
        end else begin
          pm_b = 2'($urandom);
          stop2_b = 1'($urandom);
        end
      end
      repeat (sel == 0 ? 16 : 8) tick();
    end
  endtask
  // reference: what a character on the line should decode to, from the frame's own bits
  task automatic model(input logic [8:0] d, input logic [1:0] pm, input logic pb,
                       input logic s1, input logic s2, input logic st2,
                       output logic brk, output logic [10:0] rec);
    logic x, pen, pe, fe;
    x   = ^d;
    pen = pm == 2'b01 || pm == 2'b10;
    pe  = pm == 2'b01 ? (x ^ pb) : pm == 2'b10 ? !(x ^ pb) : 1'b0;
    fe  = !s1 || (st2 && !s2);
    brk = d == 9'd0 && (!pen || !pb) && !s1 && (!st2 || !s2);
    rec = {pe, fe, d};
  endtask
  task automatic run_frame(input int sel, input logic [8:0] din, input logic [1:0] pm,
                           input logic pb, input logic s1, input logic s2, input logic st2,
                           input logic scramble, input string tag);
    logic [15:0] v;
    int n, nb;
    logic brk;
    logic [10:0] rec;
    logic [8:0] d;
    nb = sel == 0 ? 8 : 5;
    d = sel == 0 ? (din & 9'h0ff) : (din & 9'h01f);
    if (sel == 0) begin pm_a = pm; stop2_a = st2; ready_a = 1'b1; end
    else begin pm_b = pm; stop2_b = st2; ready_b = 1'b1; end
    clr();
    build(nb, d, pm, pb, s1, s2, st2, v, n);
    send(sel, v, n, scramble);
    idle(sel, 2);
    model(d, pm, pb, s1, s2, st2, brk, rec);
    if (sel == 0) begin
      check({tag, "_brk"}, nbrk_a, brk ? 1 : 0);
      check({tag, "_cnt"}, got_a.size(), brk ? 0 : 1);
      if (!brk && got_a.size() > 0) check({tag, "_char"}, got_a[0], rec);
      check({tag, "_ovr"}, novr_a, 0);
    end else begin
      check({tag, "_brk"}, nbrk_b, brk ? 1 : 0);
      check({tag, "_cnt"}, got_b.size(), brk ? 0 : 1);
      if (!brk && got_b.size() > 0) check({tag, "_char"}, got_b[0], rec);
      check({tag, "_ovr"}, novr_b, 0);
    end
  endtask
  initial begin
    logic [15:0] v;
    int n;
    logic [8:0] d;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_a", valid_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_flags_a", {par_a, frm_a, ovr_a, brk_a}, 0);
    check("rst_valid_b", {valid_b, data_b}, 0);
    run_frame(0, 9'h0a5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "a5");
    run_frame(0, 9'h007, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "even_bad");
    run_frame(0, 9'h007, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "even_ok");
    run_frame(0, 9'h03c, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "stop2_low");
    run_frame(0, 9'h05e, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "cfg_held");
    // overrun: two characters with nobody draining
    ready_a = 1'b0; pm_a = 2'b00; stop2_a = 1'b0;
    clr();
    build(8, 9'h011, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, v, n);
    send(0, v, n, 1'b0);
    idle(0, 1);
    build(8, 9'h022, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, v, n);
    send(0, v, n, 1'b0);
    idle(0, 2);
    check("ovr_valid", valid_a, 1);
    check("ovr_data", data_a, 8'h11);
    check("ovr_pulses", novr_a, 1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(posedge clk);
    #1 ready_a = 1'b0;
    check("ovr_drained", valid_a, 0);
    check("ovr_accept_n", got_a.size(), 1);
    if (got_a.size() > 0) check("ovr_accept_d", got_a[0][7:0], 8'h11);
    ready_a = 1'b1;
    // short low pulse is a glitch, not a start bit
    clr();
    rxd_a = 1'b0;
    repeat (4) tick();
    idle(0, 2);
    check("glitch_cnt", got_a.size(), 0);
    check("glitch_brk", nbrk_a, 0);
    // break: line low for 12 bit times
    clr();
    pm_a = 2'b00; stop2_a = 1'b0;
    rxd_a = 1'b0;
    repeat (12 * 16) tick();
    idle(0, 2);
    check("brk_pulses", nbrk_a, 1);
    check("brk_cnt", got_a.size(), 0);
    run_frame(0, 9'h05a, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "after_brk");
    for (int i = 0; i < 30; i++) begin
      d = 9'($urandom);
      if ($urandom_range(0, 5) == 0) d = '0;
      run_frame(0, d, 2'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0, "rnd_a");
    end
    run_frame(1, 9'h015, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "b_odd15");
    run_frame(1, 9'h015, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "b_odd15_bad");
    for (int i = 0; i < 20; i++) begin
      d = 9'($urandom);
      if ($urandom_range(0, 5) == 0) d = '0;
      run_frame(1, d, 2'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0, "rnd_b");
    end
    // reset in the middle of the data bits drops the character silently
    clr();
    pm_b = 2'b10; stop2_b = 1'b0;
    build(5, 9'h00a, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, v, n);
    send(1, v, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rxd_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1, 12);
    check("rstmid_cnt", got_b.size(), 0);
    check("rstmid_err", {nbrk_b[7:0], novr_b[7:0]}, 0);
    check("rstmid_valid", valid_b, 0);
    run_frame(1, 9'h01b, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "b_after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
